rx_share_sequencer: RTL
=======================

// Module: rx_share_sequencer
// PURPOSE
//  Sequences one shared receive datapath (RxReg, bit/cycle counter, comparator) among N_REQ requesters.
//  Round-robin arbitration, then the load/clear/count/compare sequence on behalf of the winner.
//  Ends with a one-cycle ack to that requester.
//  Sits between channel front-ends and the datapath; supersedes per-channel single-user control.
// PARAMETERS
//  N_REQ    4    number of requesters, 1..16
//  SEL_W    2    width of sel, = clog2(N_REQ), minimum 1
//  TMO_W    8    watchdog counter width
//  TMO_MAX  200  COUNT cycles before forced abort, 1..2^TMO_W-1
// PORTS
//  clock     in   1      single clock; all state updates on rising edge
//  reset     in   1      synchronous, active-low; sampled on rising clock edge
//  req       in   N_REQ  per-requester service request, level; held until ack
//  comp_out  in   1      datapath comparator; 1 = keep counting, 0 = terminal reached
//  grant     out  N_REQ  one-hot owner of datapath, 0 when idle
//  sel       out  SEL_W  binary index of owner; datapath mux select
//  RxReg_ld  out  1      load receive register (one cycle)
//  count_clr out  1      clear datapath counter (one cycle, same cycle as RxReg_ld)
//  count_en  out  1      increment datapath counter
//  ack       out  N_REQ  one-hot, one-cycle completion pulse to owner
//  err       out  1      valid with ack; 1 = watchdog abort
//  busy      out  1      1 in any state except IDLE
// BEHAVIOUR
//  Reset (reset==0 at edge):
//   - state=IDLE, rr_ptr=0, grant=0, sel=0, ack=0, err=0, busy=0
//   - RxReg_ld=0, count_clr=0, count_en=0, watchdog=0
//   - Overrides any in-flight operation; no ack is issued for it.
//  All outputs are registered or pure decodes of registered state; no comb path from req/comp_out to outputs.
//  FSM states: IDLE, LOAD, COUNT, DONE.
//   - IDLE: if |req, winner = first set bit scanning from rr_ptr upward with wrap.
//     Latch grant/sel, go to LOAD. Else stay.
//   - LOAD: RxReg_ld=1, count_clr=1 for exactly one cycle; watchdog<=0; go to COUNT.
//   - COUNT: count_en = comp_out (combinational decode allowed for this one output only).
//     On comp_out==0: go to DONE, err<=0.
//     Else if watchdog==TMO_MAX-1: go to DONE, err<=1.
//     Else watchdog++.
//   - DONE: ack[sel]=1 and err valid for one cycle; rr_ptr<=(sel+1) mod N_REQ; grant<=0; go to IDLE.
//  Latency:
//   - req rising in IDLE at edge t -> grant/LOAD at t+1 -> first COUNT at t+2.
//   - Minimum req->ack is 3 cycles (comp_out=0 on first COUNT cycle, count_en never asserted).
//  grant/sel are stable from LOAD through DONE inclusive.
//  Boundaries:
//   - Simultaneous requests: pure round-robin from rr_ptr. No requester starves; max wait is N_REQ-1 services.
//   - Owner drops req mid-operation: ignored, sequence completes, ack still issued.
//   - New/other reqs during busy: ignored until IDLE.
//   - Back-to-back: DONE->IDLE costs one idle cycle, so the earliest next LOAD is 2 cycles after ack.
//   - rr_ptr wraps N_REQ-1 -> 0.
//   - Non-power-of-2 N_REQ: indices >= N_REQ are never granted.
//   - N_REQ=1: sel stays 0, arbitration trivial.
//   - comp_out X/changes only sampled in COUNT.
//   - Watchdog does not count in other states.
// STRUCTURE
//  Shared package rx_share_pkg: state encoding constants (IDLE=2'd0, LOAD=2'd1, COUNT=2'd2, DONE=2'd3).
//  Sub-module rr_arbiter (N_REQ, SEL_W):
//   - inputs req and ptr; outputs gnt_onehot, gnt_idx, any.
//   - Purely combinational; the sequencer latches its result in IDLE.
//  Top holds FSM, rr_ptr, watchdog, output registers.
// TESTING
//  1. reset low 2 cycles with req=4'b1111 -> all outputs 0, busy=0; release -> grant=4'b0001 next cycle.
//  2. req=4'b0100 held, comp_out high 5 COUNT cycles then 0.
//     -> RxReg_ld & count_clr one cycle, count_en exactly 5 cycles, ack=4'b0100, err=0.
//  3. req=4'b1111 held, comp_out=0 -> grants in order 0001, 0010, 0100, 1000, 0001; ack each; no skips.
//  4. req=4'b0010, comp_out stuck 1, TMO_MAX=200 -> count_en 200 cycles, then ack=4'b0010, err=1.
//  5. reset asserted during COUNT -> next cycle all outputs 0, no ack, rr_ptr=0; next grant from index 0.
//  6. Owner drops req in LOAD; comp_out falls after 3 cycles -> ack still pulses, then busy=0, grant=0.

Source files
------------

// File: rtl/rx_share_pkg.sv
// ----------------------------------------------------------------------------
// rx_share_pkg
//
// Shared definitions for the receive-datapath sequencer and its arbiter.
//
// Contents:
//   state_e   - sequencer FSM state encoding (IDLE, LOAD, COUNT, DONE)
//   wrap_add  - modular index addition used for round-robin scanning and
//               for advancing the round-robin pointer
// ----------------------------------------------------------------------------
package rx_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // (a + b) mod n for small non-negative operands; n is at least 1.
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/rx_share_sequencer_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational round-robin arbiter. Starting at index ptr and
// scanning upward with wrap, the first requester with its req bit set wins.
// Only indices below N_REQ are ever considered, so a non-power-of-2 N_REQ
// can never produce an out-of-range grant.
//
// Ports:
//   req         in   N_REQ  request vector
//   ptr         in   SEL_W  index with highest priority this round
//   gnt_onehot  out  N_REQ  one-hot winner, 0 when no request
//   gnt_idx     out  SEL_W  binary index of the winner, 0 when no request
//   any         out  1      at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter
    import rx_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    // Outer loop walks priority distance from ptr; inner loop finds the
    // requester sitting at that distance. The first hit freezes the result.
    // Indexing only with loop variables keeps every select statically sized.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        for (int d = 0; d < N_REQ; d++) begin
            for (int b = 0; b < N_REQ; b++) begin
                if (!any && req[b] && (b == wrap_add(int'(ptr), d, N_REQ))) begin
                    any           = 1'b1;
                    gnt_onehot[b] = 1'b1;
                    gnt_idx       = SEL_W'(b);
                end
            end
        end
    end

endmodule

// File: rtl/rx_share_sequencer.sv
// ----------------------------------------------------------------------------
// rx_share_sequencer
//
// Shares one receive datapath (RxReg, bit/cycle counter, comparator) among
// N_REQ requesters. A round-robin arbiter picks an owner in IDLE; the
// sequencer then loads the receive register and clears the counter (LOAD),
// lets the counter run while the comparator says so (COUNT, guarded by a
// watchdog), and finally pulses ack to the owner for one cycle (DONE).
//
// Ports:
//   clock      in   1      rising-edge clock
//   reset      in   1      synchronous, active-low
//   req        in   N_REQ  level service requests, held until ack
//   comp_out   in   1      datapath comparator: 1 keep counting, 0 terminal
//   grant      out  N_REQ  one-hot datapath owner, 0 when idle
//   sel        out  SEL_W  binary owner index (datapath mux select)
//   RxReg_ld   out  1      load receive register (LOAD cycle)
//   count_clr  out  1      clear datapath counter (LOAD cycle)
//   count_en   out  1      increment datapath counter (COUNT and comp_out)
//   ack        out  N_REQ  one-cycle completion pulse to the owner
//   err        out  1      qualifies ack: 1 = watchdog abort
//   busy       out  1      sequencer not in IDLE
// ----------------------------------------------------------------------------
module rx_share_sequencer
    import rx_share_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int SEL_W   = 2,
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             comp_out,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             RxReg_ld,
    output logic             count_clr,
    output logic             count_en,
    output logic [N_REQ-1:0] ack,
    output logic             err,
    output logic             busy
);

    // Last watchdog value before a forced abort: the watchdog reads
    // 0..TMO_MAX-1 across the COUNT cycles, giving TMO_MAX cycles in total.
    localparam logic [TMO_W-1:0] WD_LAST = TMO_W'(TMO_MAX - 1);

    state_e           state_q,  state_d;
    logic [N_REQ-1:0] grant_q,  grant_d;
    logic [SEL_W-1:0] sel_q,    sel_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0] wd_q,     wd_d;
    logic             err_q,    err_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [SEL_W-1:0] arb_idx;
    logic             arb_any;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_arb (
        .req        (req),
        .ptr        (rr_ptr_q),
        .gnt_onehot (arb_gnt),
        .gnt_idx    (arb_idx),
        .any        (arb_any)
    );

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        wd_d     = wd_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                // The arbiter result is only latched here; requests seen
                // while busy have no effect.
                if (arb_any) begin
                    grant_d = arb_gnt;
                    sel_d   = arb_idx;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                wd_d    = '0;
                state_d = ST_COUNT;
            end

            ST_COUNT: begin
                // comp_out is sampled in this state only.
                if (!comp_out) begin
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end

            ST_DONE: begin
                // Priority moves to the requester just after the owner, so
                // every requester is served within N_REQ-1 other services.
                rr_ptr_d = SEL_W'(wrap_add(int'(sel_q), 1, N_REQ));
                grant_d  = '0;
                err_d    = 1'b0;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            wd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: registers or decodes of registered state, except count_en,
    // which follows comp_out combinationally during COUNT.
    // ------------------------------------------------------------------------
    assign grant     = grant_q;
    assign sel       = sel_q;
    assign RxReg_ld  = (state_q == ST_LOAD);
    assign count_clr = (state_q == ST_LOAD);
    assign count_en  = (state_q == ST_COUNT) && comp_out;
    // grant_q is one-hot at sel_q, so it is exactly ack[sel] during DONE.
    assign ack       = (state_q == ST_DONE) ? grant_q : '0;
    assign err       = err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
